// File: rtl/arbiter_mux_if.sv
// Handshake bundle between the requesting ports, the round-robin arbiter and
// the shared downstream sink, as seen by arbiter_mux.
interface arbiter_mux_if #(
  parameter int NUM_PORTS  = 6,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]            in_last;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [NUM_PORTS-1:0]            request;
  logic [NUM_PORTS-1:0]            grant;
  logic                            active;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_last;
  logic                            out_ready;

  // Environment side: ports, arbiter and downstream sink.
  modport master (
    output in_valid, in_data, in_last, grant, active, out_ready,
    input  in_ready, request, out_valid, out_data, out_last
  );

  // Mux side.
  modport slave (
    input  in_valid, in_data, in_last, grant, active, out_ready,
    output in_ready, request, out_valid, out_data, out_last
  );
endinterface

// File: rtl/arbiter_mux.sv
// Packet-locked output mux behind a round-robin arbiter: one registered beat stage.
// Optional stall watchdog enabled by defining ARBITER_MUX_TIMEOUT_EN.
module arbiter_mux #(
  parameter int NUM_PORTS      = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  arbiter_mux_if.slave bus
`ifdef ARBITER_MUX_TIMEOUT_EN
  ,
  output logic timeout
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t                 state_q;
  logic [NUM_PORTS-1:0]   owner_q;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_last_q;

  logic                   space;
  logic                   accept;
  logic                   stall_hit;
  logic [NUM_PORTS-1:0]   ready_vec;
  logic [NUM_PORTS-1:0]   req_vec;
  logic [DATA_WIDTH-1:0]  sel_data_d;
  logic                   sel_last_d;

  always_comb begin
    space      = ~out_valid_q | bus.out_ready;
    ready_vec  = (!rst && bus.active && space && (state_q != RELEASE)) ? bus.grant : '0;
    accept     = |(bus.in_valid & ready_vec);
    // Owner keeps requesting through valid bubbles and drops out for the RELEASE cycle.
    req_vec    = (bus.in_valid | ({NUM_PORTS{state_q == XFER}} & owner_q))
               & ~({NUM_PORTS{state_q == RELEASE}} & owner_q)
               & {NUM_PORTS{~rst}};
    sel_data_d = '0;
    sel_last_d = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.grant[i]) begin
        sel_data_d = sel_data_d | bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last_d = sel_last_d | bus.in_last[i];
      end
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.request   = req_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

`ifdef ARBITER_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_q;
  logic             timeout_q;

  assign stall_hit = (state_q == XFER) && !accept
                  && (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_hit;
      if ((state_q != XFER) || accept || stall_hit) stall_q <= '0;
      else                                         stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data_d;
        out_last_q  <= sel_last_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= bus.grant;
            state_q <= sel_last_d ? RELEASE : XFER;
          end
        end
        XFER: begin
          if ((accept && sel_last_d) || stall_hit) state_q <= RELEASE;
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
